// File: rtl/mole_scheduler_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
// Holds state encodings, widths, default timing and a popcount helper.
package mole_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  localparam int NUM_HOLES = 16;
  localparam int CNT_W     = 5;
  localparam int GAP_W     = 16;
  localparam int TIMER_W   = 16;

  localparam int DEF_MAX_MOLES    = 4;
  localparam int DEF_SPAWN_GAP    = 250;
  localparam int DEF_LIFETIME     = 750;
  localparam int DEF_GAP_MIN      = 50;
  localparam int DEF_GAP_STEP     = 25;
  localparam int DEF_SPEEDUP_HITS = 5;

  function automatic logic [CNT_W-1:0] popcount16(input logic [NUM_HOLES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_HOLES; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mole_scheduler_slot.sv
// One LED hole: lit bit plus lifetime countdown.
// Emits per-cycle hit/miss/expire events; clear forces the slot dark.
module mole_scheduler_slot
  import mole_scheduler_pkg::*;
#(
  parameter int LIFETIME = DEF_LIFETIME
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic spawn,
  input  logic whack,
  output logic lit,
  output logic lit_next,
  output logic hit,
  output logic miss,
  output logic expire
);

  logic [TIMER_W-1:0] timer;

  // Hit beats expiry because expire requires no whack this cycle.
  always_comb begin
    hit      = lit && whack && !clear;
    miss     = !lit && whack && !clear;
    expire   = lit && !whack && (timer == '0) && !clear;
    lit_next = lit;
    if (clear)              lit_next = 1'b0;
    else if (spawn)         lit_next = 1'b1;
    else if (hit || expire) lit_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lit   <= 1'b0;
      timer <= '0;
    end else begin
      lit <= lit_next;
      if (spawn)                 timer <= TIMER_W'(LIFETIME - 1);
      else if (hit || expire)    timer <= '0;
      else if (lit && timer != '0) timer <= timer - TIMER_W'(1);
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Round sequencer: IDLE/RUN/DRAIN FSM, spawn gap counter, spawn qualification
// and per-cycle hit/miss/expire counts. Optional MOLE_SPEEDUP_EN shrinks the gap.
module mole_scheduler
  import mole_scheduler_pkg::*;
#(
  parameter int MAX_MOLES    = DEF_MAX_MOLES,
  parameter int SPAWN_GAP    = DEF_SPAWN_GAP,
  parameter int LIFETIME     = DEF_LIFETIME
`ifdef MOLE_SPEEDUP_EN
  ,
  parameter int GAP_MIN      = DEF_GAP_MIN,
  parameter int GAP_STEP     = DEF_GAP_STEP,
  parameter int SPEEDUP_HITS = DEF_SPEEDUP_HITS
`endif
) (
  input  logic        clk_500hz,
  input  logic        rst_game,
  input  logic        start,
  input  logic        stop,
  input  logic [3:0]  random,
  input  logic [15:0] switches,
  output logic        lfsr_enable,
  output logic [15:0] leds,
  output logic [4:0]  moles_active,
  output logic [4:0]  hits,
  output logic [4:0]  misses,
  output logic [4:0]  expires,
  output logic [1:0]  state
);

  state_t                state_q;
  logic [GAP_W-1:0]      gap_cnt;
  logic [GAP_W-1:0]      gap_reload;
  logic [NUM_HOLES-1:0]  sw_prev;
  logic [NUM_HOLES-1:0]  whack_vec;
  logic [NUM_HOLES-1:0]  spawn_vec;
  logic [NUM_HOLES-1:0]  lit_next_vec;
  logic [NUM_HOLES-1:0]  hit_vec;
  logic [NUM_HOLES-1:0]  miss_vec;
  logic [NUM_HOLES-1:0]  exp_vec;
  logic                  run;
  logic                  slot_clear;
  logic                  spawn_ok;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_MOLES);

  assign state      = state_q;
  assign run        = (state_q == ST_RUN);
  assign whack_vec  = switches ^ sw_prev;
  assign slot_clear = !run || stop;

  // Cap uses the registered count; a same-cycle clear frees a slot only next cycle.
  assign spawn_ok  = run && !stop && (gap_cnt == '0) && !leds[random] &&
                     (moles_active < MAX_C) && !whack_vec[random];
  assign spawn_vec = spawn_ok ? (NUM_HOLES'(1) << random) : '0;

  for (genvar g = 0; g < NUM_HOLES; g++) begin : g_slot
    mole_scheduler_slot #(.LIFETIME(LIFETIME)) u_slot (
      .clk      (clk_500hz),
      .rst      (rst_game),
      .clear    (slot_clear),
      .spawn    (spawn_vec[g]),
      .whack    (whack_vec[g]),
      .lit      (leds[g]),
      .lit_next (lit_next_vec[g]),
      .hit      (hit_vec[g]),
      .miss     (miss_vec[g]),
      .expire   (exp_vec[g])
    );
  end

`ifdef MOLE_SPEEDUP_EN
  localparam int ACC_W = CNT_W + 1;
  logic [GAP_W-1:0] gap_eff;
  logic [CNT_W-1:0] hit_acc;
  logic [ACC_W-1:0] acc_sum;

  assign acc_sum    = {1'b0, hit_acc} + {1'b0, popcount16(hit_vec)};
  assign gap_reload = gap_eff - GAP_W'(1);

  always_ff @(posedge clk_500hz) begin
    if (rst_game || (state_q == ST_IDLE && start && !stop)) begin
      gap_eff <= GAP_W'(SPAWN_GAP);
      hit_acc <= '0;
    end else if (run && !stop) begin
      if (acc_sum >= ACC_W'(SPEEDUP_HITS)) begin
        hit_acc <= CNT_W'(acc_sum - ACC_W'(SPEEDUP_HITS));
        gap_eff <= (gap_eff >= GAP_W'(GAP_MIN + GAP_STEP)) ? gap_eff - GAP_W'(GAP_STEP)
                                                           : GAP_W'(GAP_MIN);
      end else begin
        hit_acc <= CNT_W'(acc_sum);
      end
    end
  end
`else
  assign gap_reload = GAP_W'(SPAWN_GAP - 1);
`endif

  always_ff @(posedge clk_500hz) begin
    if (rst_game) begin
      state_q      <= ST_IDLE;
      gap_cnt      <= '0;
      lfsr_enable  <= 1'b0;
      moles_active <= '0;
      hits         <= '0;
      misses       <= '0;
      expires      <= '0;
      sw_prev      <= switches;
    end else begin
      sw_prev      <= switches;
      moles_active <= popcount16(lit_next_vec);
      hits         <= popcount16(hit_vec);
      misses       <= popcount16(miss_vec);
      expires      <= popcount16(exp_vec);
      case (state_q)
        ST_IDLE: begin
          lfsr_enable <= 1'b0;
          if (start && !stop) begin
            state_q     <= ST_RUN;
            gap_cnt     <= GAP_W'(SPAWN_GAP - 1);
            lfsr_enable <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q     <= ST_DRAIN;
            lfsr_enable <= 1'b0;
          end else if (spawn_ok) begin
            gap_cnt <= gap_reload;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          lfsr_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
